// File: rtl/fifo_mem_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_mem_ctrl
//
// Purpose:
//   Sequences an external dual-port memory (registered 1-cycle read) as a FIFO.
//   Owns the write/read pointers, the occupancy count, the full/empty and
//   almost-full/almost-empty flags, and the overflow/underflow error flags.
//   The memory instance is external and is driven only by this block.
//
// Build option:
//   FIFO_ERR_STICKY_EN  defined     -> err_overflow/err_underflow hold at 1
//                                      until rst.
//                       not defined -> error flags are one-cycle pulses,
//                                      one pulse per rejected request.
//
// Ports:
//   clk, rst        clock (posedge) and asynchronous active-high reset
//   push, data_in   producer write request and its data
//   pop             consumer read request
//   data_out        popped data, qualified by valid_out (one cycle after pop)
//   umbral_af/ae    almost-full / almost-empty thresholds, captured in INIT
//   mem_write_rq, mem_w_address, mem_write_data   memory write port
//   mem_read_rq,  mem_r_address, mem_read_data    memory read port
//   fifo_count      occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty        status flags
//   err_overflow, err_underflow                   error flags (registered)
// -----------------------------------------------------------------------------
module fifo_mem_ctrl #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic [ADDR_WIDTH-1:0] umbral_af,
    input  logic [ADDR_WIDTH-1:0] umbral_ae,
    output logic                  mem_write_rq,
    output logic [ADDR_WIDTH-1:0] mem_w_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read_rq,
    output logic [ADDR_WIDTH-1:0] mem_r_address,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,  rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,   count_d;
    logic [ADDR_WIDTH-1:0] af_q,      af_d;
    logic [ADDR_WIDTH-1:0] ae_q,      ae_d;
    logic                  valid_q,   valid_d;
    logic                  err_ov_q,  err_ov_d;
    logic                  err_un_q,  err_un_d;

    logic active;
    logic full_w;
    logic empty_w;
    logic wr_accept;
    logic rd_accept;
    logic ov_event;
    logic un_event;

    // Flags come straight from the registered count.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RESET;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // All-ones keeps almost_full low until real thresholds are
            // captured; count never reaches this before ACTIVE.
            af_q     <= '1;
            ae_q     <= '0;
            valid_q  <= 1'b0;
            err_ov_q <= 1'b0;
            err_un_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            valid_q  <= valid_d;
            err_ov_q <= err_ov_d;
            err_un_q <= err_un_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and request acceptance
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        af_d      = af_q;
        ae_d      = ae_q;
        active    = 1'b0;

        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT: begin
                state_d = ST_ACTIVE;
                af_d    = umbral_af;
                ae_d    = umbral_ae;
            end
            ST_ACTIVE: active = 1'b1;
            default:   state_d = ST_RESET;
        endcase

        // Requests outside ACTIVE are simply ignored; a rejected request
        // produces only its error event.
        wr_accept = active && push && !full_w;
        rd_accept = active && pop  && !empty_w;
        ov_event  = active && push &&  full_w;
        un_event  = active && pop  &&  empty_w;

        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Memory read data appears one cycle after the read request.
        valid_d = rd_accept;

`ifdef FIFO_ERR_STICKY_EN
        err_ov_d = err_ov_q | ov_event;
        err_un_d = err_un_q | un_event;
`else
        err_ov_d = ov_event;
        err_un_d = un_event;
`endif
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_write_rq   = wr_accept;
    assign mem_w_address  = wr_ptr_q;
    assign mem_write_data = wr_accept ? data_in : '0;
    assign mem_read_rq    = rd_accept;
    assign mem_r_address  = rd_ptr_q;

    // Masked while not valid so the output stays quiet in reset and idle.
    assign data_out       = valid_q ? mem_read_data : '0;
    assign valid_out      = valid_q;

    assign fifo_count     = count_q;
    assign full           = full_w;
    assign empty          = empty_w;
    assign almost_full    = (count_q >= {1'b0, af_q});
    assign almost_empty   = (count_q <= {1'b0, ae_q});
    assign err_overflow   = err_ov_q;
    assign err_underflow  = err_un_q;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_mem_ctrl
//
// Drives fifo_mem_ctrl together with a behavioural model of the external
// dual-port memory. Expected behaviour comes from a queue-based FIFO model;
// a directed vector table covers the fill/overflow/drain/underflow corners.
// -----------------------------------------------------------------------------
module tb_fifo_mem_ctrl;

    localparam int DW    = 5;
    localparam int AW    = 4;
    localparam int DEPTH = 8;
`ifdef FIFO_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW-1:0] umbral_af;
    logic [AW-1:0] umbral_ae;
    logic          mem_write_rq;
    logic [AW-1:0] mem_w_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_read_rq;
    logic [AW-1:0] mem_r_address;
    logic [DW-1:0] mem_read_data;
    logic [AW:0]   fifo_count;
    logic          full, empty, almost_full, almost_empty;
    logic          err_overflow, err_underflow;

    always #5 clk = ~clk;

    fifo_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .data_in        (data_in),
        .pop            (pop),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .umbral_af      (umbral_af),
        .umbral_ae      (umbral_ae),
        .mem_write_rq   (mem_write_rq),
        .mem_w_address  (mem_w_address),
        .mem_write_data (mem_write_data),
        .mem_read_rq    (mem_read_rq),
        .mem_r_address  (mem_r_address),
        .mem_read_data  (mem_read_data),
        .fifo_count     (fifo_count),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow)
    );

    // External memory: synchronous write, registered read.
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_write_rq) mem_arr[mem_w_address] <= mem_write_data;
        if (mem_read_rq)  mem_read_data <= mem_arr[mem_r_address];
    end

    // ---------------- reference model ----------------
    int checks = 0;
    int errors = 0;
    int m_q[$];
    bit m_active;
    int m_edges;
    int m_wr_total, m_rd_total;
    bit m_ov, m_un, m_valid;
    int m_data;
    int m_af, m_ae;
    int txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active   = 1'b0;
        m_edges    = 0;
        m_wr_total = 0;
        m_rd_total = 0;
        m_ov       = 1'b0;
        m_un       = 1'b0;
        m_valid    = 1'b0;
        m_data     = 0;
        m_af       = 1 << AW;   // unreachable: almost_full low before thresholds are captured
        m_ae       = 0;
    endtask

    task automatic check_state();
        chk("count", fifo_count, m_q.size());
        chk("full", full, m_q.size() == DEPTH);
        chk("empty", empty, m_q.size() == 0);
        chk("almost_full", almost_full, m_q.size() >= m_af);
        chk("almost_empty", almost_empty, m_q.size() <= m_ae);
        chk("err_overflow", err_overflow, m_ov);
        chk("err_underflow", err_underflow, m_un);
        chk("valid_out", valid_out, m_valid);
        if (m_valid) chk("data_out", data_out, m_data);
    endtask

    // One clock cycle: drive, check combinational memory requests, advance
    // the clock and the model, then check registered state.
    task automatic cycle(input bit p, input bit q, input logic [DW-1:0] d);
        bit acc_w, acc_r, ev_ov, ev_un;
        int popped;
        push = p; pop = q; data_in = d;
        #1;
        acc_w = m_active && p && (m_q.size() < DEPTH);
        acc_r = m_active && q && (m_q.size() > 0);
        ev_ov = m_active && p && (m_q.size() == DEPTH);
        ev_un = m_active && q && (m_q.size() == 0);
        chk("mem_write_rq", mem_write_rq, acc_w);
        chk("mem_read_rq", mem_read_rq, acc_r);
        if (acc_w) begin
            chk("mem_w_address", mem_w_address, m_wr_total % DEPTH);
            chk("mem_write_data", mem_write_data, d);
        end
        if (acc_r) chk("mem_r_address", mem_r_address, m_rd_total % DEPTH);
        @(posedge clk);
        #1;
        popped = 0;
        if (acc_r) begin popped = m_q.pop_front(); m_rd_total++; end
        if (acc_w) begin m_q.push_back(int'(d)); m_wr_total++; end
        m_ov    = STICKY ? (m_ov | ev_ov) : ev_ov;
        m_un    = STICKY ? (m_un | ev_un) : ev_un;
        m_valid = acc_r;
        m_data  = popped;
        if (!m_active) begin
            m_edges++;
            if (m_edges == 2) begin
                m_active = 1'b1;
                m_af = umbral_af;
                m_ae = umbral_ae;
            end
        end
        txn++;
        $display("txn %0d push=%0b pop=%0b din=%0d count=%0d valid=%0b dout=%0d",
                 txn, p, q, d, fifo_count, valid_out, data_out);
        check_state();
    endtask

    // Asynchronous reset asserted between clock edges, held for n edges.
    task automatic do_reset(input int n);
        push = 1'b0; pop = 1'b0; data_in = '0;
        rst = 1'b1;
        #1;
        model_reset();
        check_state();
        repeat (n) @(posedge clk);
        #1;
        check_state();
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            push;
        bit            pop;
        logic [DW-1:0] data;
        int            count;
        bit            full;
        bit            af;
        bit            ae;
        bit            ov;
        bit            un;
        bit            valid;
        int            dout;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(bit p, bit q, int d, int c, bit f, bit af, bit ae,
                                bit ov, bit un, bit v, int dout);
        vec_t r;
        r.push = p; r.pop = q; r.data = DW'(d); r.count = c; r.full = f;
        r.af = af; r.ae = ae; r.ov = ov; r.un = un; r.valid = v; r.dout = dout;
        return r;
    endfunction

    initial begin
        // umbral_af=6, umbral_ae=1: fill 0..7, overflow, drain, underflow,
        // then simultaneous push+pop on empty.
        for (int i = 0; i < 8; i++)
            vecs[i] = mk(1, 0, i, i + 1, i == 7, (i + 1) >= 6, (i + 1) <= 1, 0, 0, 0, 0);
        vecs[8] = mk(1, 0, 8, 8, 1, 1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            vecs[9 + k] = mk(0, 1, 0, 7 - k, 0, (7 - k) >= 6, (7 - k) <= 1, STICKY, 0, 1, k);
        vecs[17] = mk(0, 1, 0, 0, 0, 0, 1, STICKY, 1, 0, 0);
        vecs[18] = mk(1, 1, 9, 1, 0, 0, 1, STICKY, 1, 0, 0);

        umbral_af = 4'd6;
        umbral_ae = 4'd1;
        do_reset(3);

        // RESET->INIT and INIT->ACTIVE: requests must be ignored.
        cycle(1, 1, 5'd3);
        chk("init_empty", empty, 1'b1);
        cycle(1, 1, 5'd4);
        chk("init_count", fifo_count, 0);

        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].push, vecs[i].pop, vecs[i].data);
            chk("vec_count", fifo_count, vecs[i].count);
            chk("vec_full", full, vecs[i].full);
            chk("vec_af", almost_full, vecs[i].af);
            chk("vec_ae", almost_empty, vecs[i].ae);
            chk("vec_ov", err_overflow, vecs[i].ov);
            chk("vec_un", err_underflow, vecs[i].un);
            chk("vec_valid", valid_out, vecs[i].valid);
            if (vecs[i].valid) chk("vec_dout", data_out, vecs[i].dout);
        end

        // Error flag persistence: overflow then 5 idle cycles.
        do_reset(2);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, DW'(i + 10));
        cycle(1, 0, 5'd31);
        chk("ovf_flag", err_overflow, 1'b1);
        chk("ovf_count", fifo_count, 8);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        chk("ovf_after_idle", err_overflow, STICKY);

        // Drain to 3, then push+pop every cycle for 20 cycles across the wrap.
        for (int i = 0; i < 5; i++) cycle(0, 1, 0);
        chk("stream_start", fifo_count, 3);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, DW'(i + 1));
            chk("stream_count", fifo_count, 3);
        end

        // Randomized traffic, each round cut short by an asynchronous reset.
        for (int r = 0; r < 4; r++) begin
            int bias_push;
            bias_push = (r == 0) ? 70 : (r == 1) ? 30 : (r == 2) ? 50 : 90;
            umbral_af = AW'($urandom_range(1, DEPTH));
            umbral_ae = AW'($urandom_range(0, DEPTH - 1));
            do_reset(1 + $urandom_range(0, 2));
            for (int c = 0; c < 120; c++) begin
                // Threshold inputs moving after INIT must have no effect.
                if (c == 60) begin
                    umbral_af = AW'($urandom_range(1, DEPTH));
                    umbral_ae = AW'($urandom_range(0, DEPTH - 1));
                end
                cycle(($urandom % 100) < bias_push, ($urandom % 100) < 50, DW'($urandom));
            end
        end
        do_reset(1);
        chk("final_valid", valid_out, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
